// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (start, 8 data bits LSB first, optional even parity, stop)
// with a one-entry holding buffer on a valid/ready input handshake.
module uart_tx #(
    parameter int CLKS_PER_BIT = 32,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Tx,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [7:0] hold, shift;
    logic [2:0] bit_idx;
    logic buf_full, par, last, load;
    assign last = cnt == CW'(CLKS_PER_BIT - 1);
    assign load = buf_full && (state == IDLE || (state == STOP && last));
    assign tx_ready = !buf_full;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hold     <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            buf_full <= 1'b0;
            par      <= 1'b0;
            Tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            if (tx_valid && !buf_full) begin
                hold     <= tx_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            done <= state == STOP && cnt == CW'(CLKS_PER_BIT - 2);
            cnt  <= (state == IDLE || last) ? '0 : cnt + CW'(1);
            // parity is latched with the byte so later tx_data changes cannot affect it
            if (load) begin
                state <= START;
                shift <= hold;
                par   <= ^hold;
                Tx    <= 1'b0;
            end else if (last) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        Tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state <= PARITY_EN ? PARITY : STOP;
                            Tx    <= PARITY_EN ? par : 1'b1;
                        end else begin
                            Tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        Tx    <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        Tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level model of the transmitter checked every cycle, plus a
// line-sampling receiver and directed scenarios with hand-computed expectations.
module tb_uart_tx;
    localparam int C  = 32;
    localparam bit PE = 1'b1;
    localparam int FL = (PE ? 11 : 10) * C;

    logic clk = 0, rst = 0, tx_valid = 0;
    logic [7:0] tx_data = 0;
    logic tx_ready, Tx, busy, done;
    int checks = 0, errors = 0, cyc = 0;

    uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(PE)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .Tx(Tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame bit i of byte b: start, data LSB first, parity, stop
    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && PE) return ^b;
        return 1'b1;
    endfunction

    // Model: a frame occupies FL cycles from the edge it starts on
    logic m_act = 0, m_full = 0, m_hs;
    logic [7:0] m_hold, m_byte;
    int m_s = 0;
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_act  = 0;
            m_full = 0;
        end else begin
            m_hs = tx_valid && !m_full;
            cyc++;
            if (m_act && cyc - m_s >= FL) m_act = 0;
            if (!m_act && m_full) begin
                m_act  = 1;
                m_s    = cyc;
                m_byte = m_hold;
                m_full = 0;
            end
            if (m_hs) begin
                m_full = 1;
                m_hold = tx_data;
            end
        end
        #1;
        chk("tx", Tx, m_act ? fbit(m_byte, (cyc - m_s) / C) : 1'b1);
        chk("busy", busy, m_act);
        chk("done", done, m_act && (cyc - m_s == FL - 1));
        chk("tx_ready", tx_ready, !m_full);
    end

    int busy_cnt = 0, done_cnt = 0, done_cyc = 0;
    initial forever begin
        @(posedge clk); #2;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    logic [7:0] rxq[$];
    logic rxp[$], rxs[$];
    initial forever begin : rx
        logic [7:0] d;
        logic p, s;
        @(posedge clk); #2;
        if (rst && Tx === 1'b0) begin
            repeat (C / 2) @(posedge clk);
            #2;
            if (Tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(posedge clk);
                    #2 d[i] = Tx;
                end
                p = 1'b0;
                if (PE) begin
                    repeat (C) @(posedge clk);
                    #2 p = Tx;
                end
                repeat (C) @(posedge clk);
                #2 s = Tx;
                rxq.push_back(d);
                rxp.push_back(p);
                rxs.push_back(s);
            end
        end
    end

    task automatic clear();
        rxq.delete();
        rxp.delete();
        rxs.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b, output int n);
        tx_valid = 1;
        tx_data  = b;
        n = -1;
        for (int i = 0; i < 4000; i++) begin
            if (tx_ready) begin
                n = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: byte %0h never accepted", b);
        end else begin
            @(negedge clk);
        end
        tx_valid = 0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int want);
        logic ok = 0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (rxq.size() >= want && !busy) begin
                ok = 1;
                break;
            end
        end
        chk("idle_reached", ok, 1);
    endtask

    logic [7:0] lb[5] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'hD1};
    int n1, n2;
    initial begin
        #303;
        chk("rst_tx", Tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1;
        repeat (1000) @(negedge clk);
        chk("idle_done_cnt", done_cnt, 0);
        chk("idle_busy_cnt", busy_cnt, 0);
        chk("idle_rx", rxq.size(), 0);

        clear();
        send(8'hD1, n1);
        wait_idle(1);
        chk("d1_byte", rxq[0], 8'hD1);
        chk("d1_par", rxp[0], 0);
        chk("d1_stop", rxs[0], 1);
        chk("d1_done_cnt", done_cnt, 1);
        chk("d1_done_cyc", done_cyc, n1 + 352);
        chk("d1_busy", busy_cnt, 352);

        clear();
        send(8'h01, n1);
        wait_idle(1);
        chk("01_byte", rxq[0], 8'h01);
        chk("01_par", rxp[0], 1);
        clear();
        send(8'h00, n1);
        wait_idle(1);
        chk("00_byte", rxq[0], 8'h00);
        chk("00_par", rxp[0], 0);

        clear();
        send(8'hD1, n1);
        send(8'hE1, n2);
        chk("b2b_accept", n2, n1 + 2);
        wait_idle(2);
        chk("b2b_busy", busy_cnt, 704);
        chk("b2b_byte0", rxq[0], 8'hD1);
        chk("b2b_byte1", rxq[1], 8'hE1);
        chk("b2b_par1", rxp[1], 0);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_done_cyc", done_cyc, n1 + 704);

        clear();
        send(8'hA5, n1);
        while (cyc < n1 + 1 + 4 * C + C / 2) @(negedge clk);
        chk("a5_bit3", Tx, 0);
        rst = 0;
        #1;
        chk("mid_rst_tx", Tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (12 * C + 4) @(negedge clk);
        clear();
        send(8'h3C, n1);
        wait_idle(1);
        chk("3c_byte", rxq[0], 8'h3C);
        chk("3c_par", rxp[0], 0);
        chk("3c_busy", busy_cnt, 352);
        chk("3c_done_cnt", done_cnt, 1);

        clear();
        foreach (lb[i]) send(lb[i], n1);
        wait_idle(5);
        foreach (lb[i]) begin
            chk("lb_byte", rxq[i], lb[i]);
            chk("lb_par", rxp[i], 0);
            chk("lb_stop", rxs[i], 1);
        end
        chk("lb_busy", busy_cnt, 5 * 352);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
